// File: rtl/tl_ul_sram_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_ul_sram_slave_if : TL-UL A/D channel bundle between one master and one slave.
// Rev 1.0
// ---------------------------------------------------------------------------
interface tl_ul_sram_slave_if #(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned SIZE_BITS   = 3,
  parameter int unsigned SOURCE_BITS = 4,
  parameter int unsigned SINK_BITS   = 1
);
  logic [2:0]                a_opcode;
  logic [2:0]                a_param;
  logic [SIZE_BITS-1:0]      a_size;
  logic [SOURCE_BITS-1:0]    a_source;
  logic [ADDR_BITS-1:0]      a_address;
  logic [DATA_BYTES-1:0]     a_mask;
  logic [DATA_BYTES*8-1:0]   a_data;
  logic                      a_valid;
  logic                      a_ready;

  logic [3:0]                d_opcode;
  logic [1:0]                d_param;
  logic [SIZE_BITS-1:0]      d_size;
  logic [SOURCE_BITS-1:0]    d_source;
  logic [SINK_BITS-1:0]      d_sink;
  logic                      d_denied;
  logic [DATA_BYTES*8-1:0]   d_data;
  logic                      d_valid;
  logic                      d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_valid,
    input  d_ready
  );
endinterface
`default_nettype wire

// File: rtl/tl_ul_sram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_ul_sram_slave : TL-UL slave serving Get/Put from a word-addressed SRAM.
// Rev 1.0
// ---------------------------------------------------------------------------
module tl_ul_sram_slave #(
  parameter int unsigned          DATA_BYTES  = 4,
  parameter int unsigned          ADDR_BITS   = 32,
  parameter int unsigned          SIZE_BITS   = 3,
  parameter int unsigned          SOURCE_BITS = 4,
  parameter int unsigned          SINK_BITS   = 1,
  parameter int unsigned          DEPTH       = 256,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  tl_ul_sram_slave_if.slave   bus,
  output logic [7:0]          err_count
);
  localparam int unsigned c_LANE_BITS = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 0;
  localparam int unsigned c_LANE_W    = (c_LANE_BITS > 0) ? c_LANE_BITS : 1;
  localparam int unsigned c_IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_DATA_BITS = DATA_BYTES * 8;
  localparam logic [ADDR_BITS:0] c_SPAN = (ADDR_BITS + 1)'(DEPTH * DATA_BYTES);

  localparam logic [2:0] c_OP_PUT_FULL = 3'd0;
  localparam logic [2:0] c_OP_PUT_PART = 3'd1;
  localparam logic [2:0] c_OP_GET      = 3'd4;

  localparam logic [0:0] c_RESP_EMPTY = 1'b0;
  localparam logic [0:0] c_RESP_FULL  = 1'b1;

  logic [ADDR_BITS-1:0]   w_rel_addr;
  logic [ADDR_BITS-1:0]   w_align_mask;
  logic [c_IDX_BITS-1:0]  w_idx;
  logic [c_LANE_W-1:0]    w_lane;
  logic [DATA_BYTES-1:0]  w_full_mask;
  logic                   w_op_ok, w_size_ok, w_aligned, w_in_range, w_mask_ok;
  logic                   w_legal, w_accept, w_is_get;
  logic                   w_unused;

  logic [c_DATA_BITS-1:0] r_mem [DEPTH];
  logic [0:0]             r_state;
  logic [3:0]             r_d_opcode;
  logic [SIZE_BITS-1:0]   r_d_size;
  logic [SOURCE_BITS-1:0] r_d_source;
  logic                   r_d_denied;
  logic [c_DATA_BITS-1:0] r_d_data;
  logic [7:0]             r_err_count;

  assign w_rel_addr = bus.a_address - BASE_ADDR;
  assign w_idx      = w_rel_addr[c_LANE_BITS +: c_IDX_BITS];

  generate
    if (c_LANE_BITS > 0) begin : g_lane_sel
      assign w_lane = w_rel_addr[c_LANE_W-1:0];
    end else begin : g_single_lane
      assign w_lane = '0;
    end
  endgenerate

  assign w_is_get     = (bus.a_opcode == c_OP_GET);
  assign w_op_ok      = (bus.a_opcode == c_OP_PUT_FULL) || (bus.a_opcode == c_OP_PUT_PART) || w_is_get;
  assign w_size_ok    = (32'(bus.a_size) <= c_LANE_BITS);
  assign w_align_mask = ~({ADDR_BITS{1'b1}} << bus.a_size);
  assign w_aligned    = ((bus.a_address & w_align_mask) == '0);
  assign w_in_range   = (bus.a_address >= BASE_ADDR) && ({1'b0, w_rel_addr} < c_SPAN);

  // Lanes a full-data put of this size must cover, starting at the address lane.
  always_comb begin
    w_full_mask = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_full_mask[i] = (i >= int'(w_lane)) && (i < int'(w_lane) + (1 << bus.a_size));
    end
  end

  assign w_mask_ok = (bus.a_opcode != c_OP_PUT_FULL) || (bus.a_mask == w_full_mask);
  assign w_legal   = w_op_ok && w_size_ok && w_aligned && w_in_range && w_mask_ok;

  assign bus.a_ready = (r_state == c_RESP_EMPTY) || bus.d_ready;
  assign w_accept    = bus.a_valid && bus.a_ready;

  always_ff @(posedge clk) begin
    if (w_accept && w_legal && !w_is_get) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (bus.a_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.a_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_RESP_EMPTY;
      r_d_opcode  <= '0;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_data    <= '0;
      r_err_count <= '0;
    end else if (w_accept) begin
      r_state    <= c_RESP_FULL;
      r_d_opcode <= w_is_get ? 4'd1 : 4'd0;
      r_d_size   <= bus.a_size;
      r_d_source <= bus.a_source;
      r_d_denied <= !w_legal;
      // Read sees the pre-write word; only one request lands per edge anyway.
      r_d_data   <= (w_legal && w_is_get) ? r_mem[w_idx] : '0;
      if (!w_legal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end else if (bus.d_ready) begin
      r_state <= c_RESP_EMPTY;
    end
  end

  assign bus.d_valid  = (r_state == c_RESP_FULL);
  assign bus.d_opcode = r_d_opcode;
  assign bus.d_param  = '0;
  assign bus.d_size   = r_d_size;
  assign bus.d_source = r_d_source;
  assign bus.d_sink   = '0;
  assign bus.d_denied = r_d_denied;
  assign bus.d_data   = r_d_data;
  assign err_count    = r_err_count;

  assign w_unused = ^bus.a_param;
endmodule
`default_nettype wire
